// File: rtl/sevseg_capture_if.sv
// Multiplexed seven-segment display bus (segments + digit enables) and the
// decoded time and status pulses recovered from it.
interface sevseg_capture_if;
   logic [0:6] seg;
   logic [3:0] digit;
   logic [5:0] min;
   logic [5:0] sec;
   logic       frame_valid;
   logic       blank_frame;
   logic       err_glyph;
   logic       err_seq;
   logic       err_range;
   logic       err_timeout;

   modport master (
      output seg, digit,
      input  min, sec, frame_valid, blank_frame,
             err_glyph, err_seq, err_range, err_timeout
   );

   modport slave (
      input  seg, digit,
      output min, sec, frame_valid, blank_frame,
             err_glyph, err_seq, err_range, err_timeout
   );
endinterface

// File: rtl/sevseg_capture.sv
// Recovers an mm:ss reading by sniffing a four-digit multiplexed seven-segment
// display, with settle filtering, scan-order checking and frame timeout.
module sevseg_capture #(
   parameter int SETTLE  = 1,
   parameter int TIMEOUT = 1000
) (
   input logic             clk,
   input logic             rst,
   sevseg_capture_if.slave bus
);

   localparam logic [1:0]  ST_SYNC      = 2'd0;
   localparam logic [1:0]  ST_COLLECT   = 2'd1;
   localparam logic [1:0]  ST_EMIT      = 2'd2;

   localparam logic [3:0]  DIG_SEC_ONES = 4'b1110;
   localparam logic [3:0]  DIG_SEC_TENS = 4'b1101;
   localparam logic [3:0]  DIG_MIN_ONES = 4'b1011;
   localparam logic [3:0]  DIG_MIN_TENS = 4'b0111;
   localparam logic [3:0]  DIG_NONE     = 4'b1111;

   localparam logic [3:0]  VAL_BLANK    = 4'hF;
   localparam logic [7:0]  SETTLE_C     = 8'(SETTLE);
   localparam logic [15:0] TO_LAST_C    = 16'(TIMEOUT - 1);

   // Returns {legal, value}; blank is a legal glyph carrying VAL_BLANK.
   function automatic logic [4:0] decode_glyph(input logic [0:6] s);
      case (s)
         7'b0000001: decode_glyph = {1'b1, 4'd0};
         7'b1001111: decode_glyph = {1'b1, 4'd1};
         7'b0010010: decode_glyph = {1'b1, 4'd2};
         7'b0000110: decode_glyph = {1'b1, 4'd3};
         7'b1001100: decode_glyph = {1'b1, 4'd4};
         7'b0100100: decode_glyph = {1'b1, 4'd5};
         7'b0100000: decode_glyph = {1'b1, 4'd6};
         7'b0001111: decode_glyph = {1'b1, 4'd7};
         7'b0000000: decode_glyph = {1'b1, 4'd8};
         7'b0000100: decode_glyph = {1'b1, 4'd9};
         7'b1111111: decode_glyph = {1'b1, VAL_BLANK};
         default:    decode_glyph = {1'b0, 4'd0};
      endcase
   endfunction

   function automatic logic is_digit_code(input logic [3:0] d);
      case (d)
         DIG_SEC_ONES, DIG_SEC_TENS, DIG_MIN_ONES, DIG_MIN_TENS: is_digit_code = 1'b1;
         default:                                                is_digit_code = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] code_for_slot(input logic [1:0] idx);
      case (idx)
         2'd0:    code_for_slot = DIG_SEC_ONES;
         2'd1:    code_for_slot = DIG_SEC_TENS;
         2'd2:    code_for_slot = DIG_MIN_ONES;
         2'd3:    code_for_slot = DIG_MIN_TENS;
         default: code_for_slot = DIG_NONE;
      endcase
   endfunction

   logic [3:0]  digit_prev_r;
   logic [7:0]  stab_cnt_r;
   logic [7:0]  stab_next_s;
   logic        same_s;
   logic        onehot_s;
   logic        sample_s;

   logic        samp_valid_r;
   logic [3:0]  samp_code_r;
   logic        samp_legal_r;
   logic [3:0]  samp_val_r;

   logic [1:0]  state_r;
   logic [1:0]  idx_r;
   logic [3:0]  slot_r [0:3];
   logic [15:0] to_cnt_r;

   logic [6:0]  min_calc_s;
   logic [6:0]  sec_calc_s;
   logic        all_blank_s;
   logic        any_blank_s;
   logic        range_bad_s;

   logic [5:0]  min_r;
   logic [5:0]  sec_r;
   logic        frame_valid_r;
   logic        blank_frame_r;
   logic        err_glyph_r;
   logic        err_seq_r;
   logic        err_range_r;
   logic        err_timeout_r;

   // Stability count of the digit code; the strobe fires once per held code.
   always_comb begin
      same_s   = (bus.digit == digit_prev_r);
      onehot_s = is_digit_code(bus.digit);
      if (onehot_s && same_s) begin
         if (stab_cnt_r == 8'hFF) begin
            stab_next_s = 8'hFF;
         end else begin
            stab_next_s = stab_cnt_r + 8'd1;
         end
      end else begin
         stab_next_s = 8'd1;
      end
      sample_s = onehot_s && (stab_next_s == SETTLE_C) &&
                 !(same_s && (stab_cnt_r == SETTLE_C));
   end

   // Digit history, stability counter and one-stage registered sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_prev_r <= DIG_NONE;
         stab_cnt_r   <= 8'd0;
         samp_valid_r <= 1'b0;
         samp_code_r  <= DIG_NONE;
         samp_legal_r <= 1'b0;
         samp_val_r   <= 4'd0;
      end else begin
         digit_prev_r <= bus.digit;
         stab_cnt_r   <= stab_next_s;
         samp_valid_r <= sample_s;
         samp_code_r  <= bus.digit;
         {samp_legal_r, samp_val_r} <= decode_glyph(bus.seg);
      end
   end

   // Frame evaluation; blank slots make the arithmetic meaningless but are
   // screened out first by priority.
   always_comb begin
      min_calc_s  = 7'(slot_r[3]) * 7'd10 + 7'(slot_r[2]);
      sec_calc_s  = 7'(slot_r[1]) * 7'd10 + 7'(slot_r[0]);
      all_blank_s = (slot_r[0] == VAL_BLANK) && (slot_r[1] == VAL_BLANK) &&
                    (slot_r[2] == VAL_BLANK) && (slot_r[3] == VAL_BLANK);
      any_blank_s = (slot_r[0] == VAL_BLANK) || (slot_r[1] == VAL_BLANK) ||
                    (slot_r[2] == VAL_BLANK) || (slot_r[3] == VAL_BLANK);
      range_bad_s = (slot_r[1] > 4'd5) || (min_calc_s > 7'd63);
   end

   // Frame sequencer, timeout supervision and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_SYNC;
         idx_r         <= 2'd0;
         to_cnt_r      <= 16'd0;
         for (int i = 0; i < 4; i++) slot_r[i] <= 4'd0;
         min_r         <= 6'd0;
         sec_r         <= 6'd0;
         frame_valid_r <= 1'b0;
         blank_frame_r <= 1'b0;
         err_glyph_r   <= 1'b0;
         err_seq_r     <= 1'b0;
         err_range_r   <= 1'b0;
         err_timeout_r <= 1'b0;
      end else begin
         frame_valid_r <= 1'b0;
         blank_frame_r <= 1'b0;
         err_glyph_r   <= 1'b0;
         err_seq_r     <= 1'b0;
         err_range_r   <= 1'b0;
         err_timeout_r <= 1'b0;
         case (state_r)
            ST_SYNC: begin
               if (samp_valid_r && (samp_code_r == DIG_SEC_ONES)) begin
                  if (samp_legal_r) begin
                     slot_r[0] <= samp_val_r;
                     for (int i = 1; i < 4; i++) slot_r[i] <= 4'd0;
                     idx_r     <= 2'd1;
                     to_cnt_r  <= 16'd0;
                     state_r   <= ST_COLLECT;
                  end else begin
                     err_glyph_r <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               if (samp_valid_r) begin
                  to_cnt_r <= 16'd0;
                  if (!samp_legal_r) begin
                     err_glyph_r <= 1'b1;
                     for (int i = 0; i < 4; i++) slot_r[i] <= 4'd0;
                     state_r     <= ST_SYNC;
                  end else if (samp_code_r == code_for_slot(idx_r)) begin
                     slot_r[idx_r] <= samp_val_r;
                     if (idx_r == 2'd3) begin
                        state_r <= ST_EMIT;
                     end else begin
                        idx_r <= idx_r + 2'd1;
                     end
                  end else begin
                     err_seq_r <= 1'b1;
                     for (int i = 1; i < 4; i++) slot_r[i] <= 4'd0;
                     if (samp_code_r == DIG_SEC_ONES) begin
                        slot_r[0] <= samp_val_r;
                        idx_r     <= 2'd1;
                     end else begin
                        slot_r[0] <= 4'd0;
                        state_r   <= ST_SYNC;
                     end
                  end
               end else if (to_cnt_r == TO_LAST_C) begin
                  err_timeout_r <= 1'b1;
                  to_cnt_r      <= 16'd0;
                  for (int i = 0; i < 4; i++) slot_r[i] <= 4'd0;
                  state_r       <= ST_SYNC;
               end else begin
                  to_cnt_r <= to_cnt_r + 16'd1;
               end
            end
            ST_EMIT: begin
               if (all_blank_s) begin
                  blank_frame_r <= 1'b1;
               end else if (any_blank_s) begin
                  err_glyph_r <= 1'b1;
               end else if (range_bad_s) begin
                  err_range_r <= 1'b1;
               end else begin
                  min_r         <= min_calc_s[5:0];
                  sec_r         <= sec_calc_s[5:0];
                  frame_valid_r <= 1'b1;
               end
               // A back-to-back scan delivers the next seconds-ones digit here.
               if (samp_valid_r && samp_legal_r && (samp_code_r == DIG_SEC_ONES)) begin
                  slot_r[0] <= samp_val_r;
                  for (int i = 1; i < 4; i++) slot_r[i] <= 4'd0;
                  idx_r     <= 2'd1;
                  to_cnt_r  <= 16'd0;
                  state_r   <= ST_COLLECT;
               end else begin
                  idx_r   <= 2'd0;
                  state_r <= ST_SYNC;
               end
            end
            default: begin
               state_r <= ST_SYNC;
            end
         endcase
      end
   end

   assign bus.min         = min_r;
   assign bus.sec         = sec_r;
   assign bus.frame_valid = frame_valid_r;
   assign bus.blank_frame = blank_frame_r;
   assign bus.err_glyph   = err_glyph_r;
   assign bus.err_seq     = err_seq_r;
   assign bus.err_range   = err_range_r;
   assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture: one instance with SETTLE=1 and one with
// SETTLE=3, both fed the same scan stimulus.
module tb_sevseg_capture;
   localparam int TIMEOUT = 40;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sevseg_capture_if if1 ();
   sevseg_capture_if if3 ();

   sevseg_capture #(.SETTLE(1), .TIMEOUT(TIMEOUT)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   sevseg_capture #(.SETTLE(3), .TIMEOUT(TIMEOUT)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

   int vectors     = 0;
   int miscompares = 0;
   int ev1 [6];
   int ev3 [6];
   int base1 [6];
   int base3 [6];
   string nm [6] = '{"frame_valid", "blank_frame", "err_glyph", "err_seq", "err_range", "err_timeout"};
   logic [5:0] p1, p3;

   // Pulse tallies per output; at most one pulse per cycle.
   always @(negedge clk) begin
      p1 = {if1.err_timeout, if1.err_range, if1.err_seq, if1.err_glyph, if1.blank_frame, if1.frame_valid};
      p3 = {if3.err_timeout, if3.err_range, if3.err_seq, if3.err_glyph, if3.blank_frame, if3.frame_valid};
      for (int i = 0; i < 6; i++) begin
         ev1[i] = ev1[i] + (p1[i] === 1'b1 ? 1 : 0);
         ev3[i] = ev3[i] + (p3[i] === 1'b1 ? 1 : 0);
      end
      if ($countones(p1) > 1 || $countones(p3) > 1) begin
         vectors++;
         miscompares++;
         $display("FAIL pulse_exclusive: dut1=%b dut3=%b, required at most one pulse each", p1, p3);
      end
   end

   function automatic logic [0:6] glyph(input int v);
      case (v)
         0:       glyph = 7'b0000001;
         1:       glyph = 7'b1001111;
         2:       glyph = 7'b0010010;
         3:       glyph = 7'b0000110;
         4:       glyph = 7'b1001100;
         5:       glyph = 7'b0100100;
         6:       glyph = 7'b0100000;
         7:       glyph = 7'b0001111;
         8:       glyph = 7'b0000000;
         9:       glyph = 7'b0000100;
         10:      glyph = 7'b1111111;
         default: glyph = 7'b1111110;
      endcase
   endfunction

   task automatic put(input logic [3:0] d, input logic [0:6] s, input int n);
      if1.digit = d;
      if3.digit = d;
      if1.seg   = s;
      if3.seg   = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int mt, input int mo, input int st, input int so, input int hold);
      put(4'b1110, glyph(so), hold);
      put(4'b1101, glyph(st), hold);
      put(4'b1011, glyph(mo), hold);
      put(4'b0111, glyph(mt), hold);
      put(4'b1111, 7'b1111111, 4);
      #1;
   endtask

   task automatic snap();
      #1;
      for (int i = 0; i < 6; i++) begin
         base1[i] = ev1[i];
         base3[i] = ev3[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      put(4'b1111, 7'b1111111, 2);
      rst = 1'b0;
      put(4'b1111, 7'b1111111, 1);
      snap();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      put(4'b1110, glyph(5), 1);
      put(4'b1101, glyph(3), 1);
      put(4'b1011, glyph(2), 1);
      put(4'b0111, glyph(1), 2);
      #1;
      vectors++;
      if ({if1.min, if1.sec, if3.min, if3.sec} !== 24'd0) begin
         miscompares++;
         $display("FAIL reset_minsec: got %0d:%0d / %0d:%0d, expected 0:0", if1.min, if1.sec, if3.min, if3.sec);
      end
      vectors++;
      if ({p1, p3} !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b %b, expected all zero", p1, p3);
      end
      rst = 1'b0;
      put(4'b1111, 7'b1111111, 2);
      snap();
   endtask

   task automatic test_back_to_back();
      int hits[$];
      int exp[6];
      logic [3:0] order[4];
      int val[4];
      order = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      val   = '{4, 3, 2, 1};
      do_reset();
      for (int k = 0; k < 20; k++) begin
         put(order[k % 4], glyph(val[k % 4]), 1);
         #1;
         if (if1.frame_valid === 1'b1) hits.push_back(k);
      end
      put(4'b1111, 7'b1111111, 4);
      #1;
      vectors++;
      if (hits.size() != 4) begin
         miscompares++;
         $display("FAIL b2b_pulse_count: got %0d pulses in scan window, expected 4", hits.size());
      end else begin
         vectors++;
         if (hits[0] != 5) begin
            miscompares++;
            $display("FAIL b2b_latency: first frame_valid at cycle %0d, expected 5", hits[0]);
         end
         for (int i = 1; i < 4; i++) begin
            vectors++;
            if (hits[i] - hits[i-1] != 4) begin
               miscompares++;
               $display("FAIL b2b_spacing: gap %0d, expected 4", hits[i] - hits[i-1]);
            end
         end
      end
      vectors++;
      if (if1.min !== 6'd12 || if1.sec !== 6'd34) begin
         miscompares++;
         $display("FAIL b2b_value: got %0d:%0d, expected 12:34", if1.min, if1.sec);
      end
      exp = '{5, 0, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev1[i] - base1[i] != exp[i]) begin
            miscompares++;
            $display("FAIL b2b_%s: got %0d pulses, expected %0d", nm[i], ev1[i] - base1[i], exp[i]);
         end
      end
   endtask

   task automatic test_settle3();
      int hit;
      int exp[6];
      logic [3:0] order[4];
      order = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      do_reset();
      frame(5, 9, 5, 9, 3);
      vectors++;
      if (if3.min !== 6'd59 || if3.sec !== 6'd59 || ev3[0] - base3[0] != 1) begin
         miscompares++;
         $display("FAIL settle3_value: got %0d:%0d fv=%0d, expected 59:59 fv=1", if3.min, if3.sec, ev3[0] - base3[0]);
      end
      snap();
      put(4'b1110, glyph(1), 3);
      hit = 0;
      for (int c = 1; c <= 3 * TIMEOUT; c++) begin
         put(order[((c - 1) / 2) % 4], glyph(2), 1);
         #1;
         if (hit == 0 && if3.err_timeout === 1'b1) hit = c;
      end
      put(4'b1111, 7'b1111111, 2);
      #1;
      vectors++;
      if (hit < TIMEOUT || hit > TIMEOUT + 2) begin
         miscompares++;
         $display("FAIL settle3_timeout: err_timeout at cycle %0d, expected %0d..%0d", hit, TIMEOUT, TIMEOUT + 2);
      end
      vectors++;
      if (if3.min !== 6'd59 || if3.sec !== 6'd59) begin
         miscompares++;
         $display("FAIL settle3_hold: got %0d:%0d, expected 59:59", if3.min, if3.sec);
      end
      exp = '{0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev3[i] - base3[i] != exp[i]) begin
            miscompares++;
            $display("FAIL settle3_%s: got %0d pulses, expected %0d", nm[i], ev3[i] - base3[i], exp[i]);
         end
      end
   endtask

   task automatic test_blank();
      int exp[6];
      do_reset();
      frame(2, 1, 4, 5, 1);
      vectors++;
      if (if1.min !== 6'd21 || if1.sec !== 6'd45) begin
         miscompares++;
         $display("FAIL blank_setup: got %0d:%0d, expected 21:45", if1.min, if1.sec);
      end
      snap();
      frame(10, 10, 10, 10, 1);
      vectors++;
      if (ev1[1] - base1[1] != 1) begin
         miscompares++;
         $display("FAIL blank_pulse: got %0d blank_frame pulses, expected 1", ev1[1] - base1[1]);
      end
      frame(2, 1, 10, 5, 1);
      frame(2, 11, 4, 5, 1);
      vectors++;
      if (if1.min !== 6'd21 || if1.sec !== 6'd45) begin
         miscompares++;
         $display("FAIL blank_hold: got %0d:%0d, expected 21:45", if1.min, if1.sec);
      end
      exp = '{0, 1, 2, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev1[i] - base1[i] != exp[i]) begin
            miscompares++;
            $display("FAIL blank_%s: got %0d pulses, expected %0d", nm[i], ev1[i] - base1[i], exp[i]);
         end
      end
   endtask

   task automatic test_seq();
      int exp[6];
      do_reset();
      put(4'b1110, glyph(3), 1);
      put(4'b1011, glyph(4), 1);
      put(4'b1101, glyph(2), 1);
      put(4'b0111, glyph(1), 1);
      put(4'b1111, 7'b1111111, 4);
      #1;
      vectors++;
      if (ev1[3] - base1[3] != 1 || ev1[0] - base1[0] != 0 || ev1[2] - base1[2] != 0) begin
         miscompares++;
         $display("FAIL seq_skip: got seq=%0d fv=%0d glyph=%0d, expected 1 0 0",
                  ev1[3] - base1[3], ev1[0] - base1[0], ev1[2] - base1[2]);
      end
      frame(0, 0, 0, 7, 1);
      vectors++;
      if (if1.min !== 6'd0 || if1.sec !== 6'd7) begin
         miscompares++;
         $display("FAIL seq_recover: got %0d:%0d, expected 0:7", if1.min, if1.sec);
      end
      put(4'b1110, glyph(9), 1);
      put(4'b1101, glyph(9), 1);
      put(4'b1110, glyph(1), 1);
      put(4'b1101, glyph(2), 1);
      put(4'b1011, glyph(3), 1);
      put(4'b0111, glyph(0), 1);
      put(4'b1111, 7'b1111111, 4);
      #1;
      vectors++;
      if (if1.min !== 6'd3 || if1.sec !== 6'd21) begin
         miscompares++;
         $display("FAIL seq_restart: got %0d:%0d, expected 3:21", if1.min, if1.sec);
      end
      put(4'b1110, glyph(1), 1);
      put(4'b1011, glyph(12), 1);
      put(4'b1111, 7'b1111111, 4);
      #1;
      exp = '{2, 0, 1, 2, 0, 0};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev1[i] - base1[i] != exp[i]) begin
            miscompares++;
            $display("FAIL seq_%s: got %0d pulses, expected %0d", nm[i], ev1[i] - base1[i], exp[i]);
         end
      end
   endtask

   task automatic test_range();
      int exp[6];
      do_reset();
      frame(1, 0, 2, 0, 1);
      snap();
      frame(1, 0, 6, 5, 1);
      frame(6, 4, 0, 0, 1);
      vectors++;
      if (if1.min !== 6'd10 || if1.sec !== 6'd20) begin
         miscompares++;
         $display("FAIL range_hold: got %0d:%0d, expected 10:20", if1.min, if1.sec);
      end
      frame(6, 3, 5, 9, 1);
      vectors++;
      if (if1.min !== 6'd63 || if1.sec !== 6'd59) begin
         miscompares++;
         $display("FAIL range_edge: got %0d:%0d, expected 63:59", if1.min, if1.sec);
      end
      exp = '{1, 0, 0, 0, 2, 0};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev1[i] - base1[i] != exp[i]) begin
            miscompares++;
            $display("FAIL range_%s: got %0d pulses, expected %0d", nm[i], ev1[i] - base1[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int exp[6];
      do_reset();
      frame(1, 1, 1, 1, 1);
      snap();
      put(4'b1110, glyph(0), 1);
      put(4'b1101, glyph(3), 1);
      put(4'b1011, glyph(8), 1);
      rst = 1'b1;
      put(4'b1111, 7'b1111111, 2);
      rst = 1'b0;
      put(4'b0111, glyph(0), 1);
      put(4'b1111, 7'b1111111, 4);
      #1;
      vectors++;
      if (if1.min !== 6'd0 || if1.sec !== 6'd0) begin
         miscompares++;
         $display("FAIL rstmid_clear: got %0d:%0d, expected 0:0", if1.min, if1.sec);
      end
      exp = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (ev1[i] - base1[i] != exp[i]) begin
            miscompares++;
            $display("FAIL rstmid_%s: got %0d pulses, expected %0d", nm[i], ev1[i] - base1[i], exp[i]);
         end
      end
      frame(0, 8, 3, 0, 1);
      vectors++;
      if (if1.min !== 6'd8 || if1.sec !== 6'd30 || ev1[0] - base1[0] != 1) begin
         miscompares++;
         $display("FAIL rstmid_next: got %0d:%0d fv=%0d, expected 8:30 fv=1", if1.min, if1.sec, ev1[0] - base1[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 6; i++) begin
         ev1[i] = 0;
         ev3[i] = 0;
      end
      rst       = 1'b1;
      if1.digit = 4'b1111;
      if3.digit = 4'b1111;
      if1.seg   = 7'b1111111;
      if3.seg   = 7'b1111111;
      test_reset();
      test_back_to_back();
      test_settle3();
      test_blank();
      test_seq();
      test_range();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
